// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, synchronous imem issue, one-entry hold
// buffer and registered instruction/opcode/PC bundle toward decode.
module fetch_unit #(
  parameter int PC_WIDTH = 16,
  parameter int INSTR_WIDTH = 24,
  parameter logic [PC_WIDTH-1:0] START_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   halt,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic                   imem_re,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [3:0]             if_opcode,
  output logic [PC_WIDTH-1:0]    if_pc,
  output logic                   if_valid
);

  localparam logic [INSTR_WIDTH-1:0] BUBBLE =
    {4'hF, {(INSTR_WIDTH-4){1'b0}}};

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    fpc_q, fpc_d;
  logic                   pending_q, pending_d;
  logic                   hold_valid_q, hold_valid_d;
  logic [INSTR_WIDTH-1:0] hold_instr_q, hold_instr_d;
  logic [PC_WIDTH-1:0]    hold_pc_q, hold_pc_d;
  logic [INSTR_WIDTH-1:0] if_instr_q, if_instr_d;
  logic [PC_WIDTH-1:0]    if_pc_q, if_pc_d;
  logic                   if_valid_q, if_valid_d;
  logic                   issue;

  assign issue = (state_q == S_RUN) & ~stall & ~branch_taken & ~halt;

  assign imem_re   = issue;
  assign imem_addr = pc_q;
  assign if_instr  = if_instr_q;
  assign if_opcode = if_instr_q[INSTR_WIDTH-1 -: 4];
  assign if_pc     = if_pc_q;
  assign if_valid  = if_valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fpc_d        = fpc_q;
    pending_d    = 1'b0;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    if_valid_d   = if_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !halt) begin
          state_d = S_RUN;
          pc_d    = START_PC;
        end
      end
      S_RUN: begin
        if (halt) begin
          state_d      = S_IDLE;
          pc_d         = START_PC;
          hold_valid_d = 1'b0;
          if_valid_d   = 1'b0;
          if_instr_d   = BUBBLE;
        end else if (branch_taken) begin
          pc_d         = branch_target;
          hold_valid_d = 1'b0;
          if_valid_d   = 1'b0;
          if_instr_d   = BUBBLE;
        end else begin
          if (issue) begin
            pc_d      = pc_q + 1'b1;
            fpc_d     = pc_q;
            pending_d = 1'b1;
          end
          // A stalled return parks in hold; no issue happens while stalled.
          if (stall) begin
            if (pending_q) begin
              hold_instr_d = imem_rdata;
              hold_pc_d    = fpc_q;
              hold_valid_d = 1'b1;
            end
          end else if (hold_valid_q) begin
            if_instr_d   = hold_instr_q;
            if_pc_d      = hold_pc_q;
            if_valid_d   = 1'b1;
            hold_valid_d = 1'b0;
          end else if (pending_q) begin
            if_instr_d = imem_rdata;
            if_pc_d    = fpc_q;
            if_valid_d = 1'b1;
          end else begin
            if_instr_d = BUBBLE;
            if_valid_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= START_PC;
      fpc_q        <= '0;
      pending_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      if_instr_q   <= BUBBLE;
      if_pc_q      <= '0;
      if_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fpc_q        <= fpc_d;
      pending_q    <= pending_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      if_valid_q   <= if_valid_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the opcode decoder.
- Keeps the program counter and drives a synchronous instruction memory with one-cycle read latency.
- Buffers returned words through a one-entry hold register so no instruction is lost or duplicated during a stall.
- Presents a registered instruction, opcode and PC to decode.
- Inserts NOP bubbles (opcode 4'hF) on start, halt, branch redirect and empty cycles. Decode therefore sees all write, read and memory enables deasserted during those cycles.

Parameters:
PC_WIDTH, 16, width of program counter and instruction memory address
INSTR_WIDTH, 24, instruction word width; opcode is the top 4 bits
START_PC, 0, PC loaded on start

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  leave IDLE and begin fetching at START_PC
halt  in  1  return to IDLE and flush
stall  in  1  hold the fetch output (downstream not ready)
branch_taken  in  1  redirect request from execute (BT resolved)
branch_target  in  PC_WIDTH  redirect address
imem_addr  out  PC_WIDTH  instruction memory address (= pc register)
imem_re  out  1  memory read issue strobe
imem_rdata  in  INSTR_WIDTH  word for the address issued in the previous cycle
if_instr  out  INSTR_WIDTH  registered instruction to decode
if_opcode  out  4  if_instr[INSTR_WIDTH-1 -: 4]
if_pc  out  PC_WIDTH  address of if_instr
if_valid  out  1  if_instr is a real instruction

Behaviour:
- Reset is asynchronous and active-low; it is the only asynchronous path.
  - state=IDLE, pc=START_PC, pending=0, hold_valid=0.
  - if_instr = {4'hF, zeros}, if_valid=0, if_pc=0, imem_re=0.
- FSM:
  - IDLE: if halt=0 and start=1, go to RUN; pc<=START_PC.
  - RUN: if halt=1, go to IDLE; pc<=START_PC; pending, hold_valid and if_valid cleared; if_instr<=bubble.
  - halt has priority over start, branch and stall.
- Issue: issue = (state==RUN) & ~stall & ~branch_taken & ~halt.
  - imem_re=issue.
  - On issue: pc<=pc+1, wrapping modulo 2^PC_WIDTH; fpc<=pc; pending<=1.
  - Otherwise: pending<=0.
- Memory timing: imem_rdata is meaningful only in the cycle after an issue (pending=1). Its address is fpc.
- Output update (RUN, no branch, no halt):
  - stall=1: if_* hold. If pending=1, capture {imem_rdata, fpc} into the hold register and set hold_valid<=1.
  - stall=0, hold_valid=1: if_*<=hold, if_valid<=1, hold_valid<=0.
  - stall=0, pending=1: if_*<=rdata/fpc, if_valid<=1.
  - stall=0, neither: if_instr<=bubble, if_valid<=0, if_pc holds.
- Hold register never overflows: no issue occurs while stall=1, so pending is 0 from the second stall cycle onward.
- Branch (RUN, branch_taken=1, halt=0) takes priority over stall:
  - pc<=branch_target; pending<=0; hold_valid<=0.
  - if_instr<=bubble; if_valid<=0.
  - The target is issued in the next non-stalled cycle. The first target instruction appears at if_* 2 cycles after the branch edge (redirect penalty 2 bubbles).
- Latency: first valid output 2 clocks after the start edge. Throughput thereafter is 1 instruction/cycle without stalls.
- When if_valid=0, if_opcode is always 4'hF.

Test Plan:
- Reset, pulse start, memory returns word=address<<8 with opcode 4'h1 → imem_addr 0,1,2…; if_valid rises 2 cycles after start; if_pc 0,1,2,3 consecutive; if_opcode 4'h1.
- Steady stream, stall=1 for 3 cycles while if_pc=4 → if_pc stays 4 during stall; then 5,6,7 with no gap-skip and no duplicate; imem_re=0 during stall.
- branch_taken=1, branch_target=0x0040 while if_pc=5 → next if_valid=0 with if_opcode=4'hF; if_pc=0x0040 valid 2 cycles after branch edge, then 0x0041.
- branch_taken and stall asserted together with hold_valid=1 → hold discarded; pc=target; output bubble; no stale instruction emitted after stall release.
- START_PC=16'hFFFE, run → if_pc sequence FFFE, FFFF, 0000, 0001.
- rst_n pulled low mid-stream (not at a clock edge) → if_valid=0, if_opcode=4'hF, imem_re=0 immediately; after release, no fetch until start.
